// File: rtl/scmp_bus_ctl_pkg.sv
// Shared types and constants for the SC/MP external bus cycle controller.
// Holds the FSM state encoding, data-bus flag positions and the address-phase byte helper.
package scmp_bus_pak;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ARB  = 2'd1,
    ST_ADDR = 2'd2,
    ST_DATA = 2'd3
  } BUS_STATE_t;

  localparam int DB_F_R = 4;
  localparam int DB_F_I = 5;
  localparam int DB_F_D = 6;
  localparam int DB_F_H = 7;

  // Wide enough for the largest strobe preload (15 - 1).
  localparam int CNT_W = 4;

  // Address-phase data-bus byte: status flags on the top nibble, A15..A12 below.
  function automatic logic [7:0] addr_phase_db(input logic [3:0] flags, input logic [15:0] addr);
    logic [7:0] db;
    db         = 8'h00;
    db[DB_F_H] = flags[3];
    db[DB_F_D] = flags[2];
    db[DB_F_I] = flags[1];
    db[DB_F_R] = flags[0];
    db[3:0]    = addr[15:12];
    return db;
  endfunction

endpackage

// File: rtl/scmp_bus_ctl_if.sv
// Sequencer-side request/response and external bus pins of the SC/MP bus controller.
// master: the controller's view; slave: the sequencer plus external bus environment.
interface scmp_bus_ctl_if;
  logic        mc_ads;
  logic        mc_rd;
  logic        mc_wr;
  logic [3:0]  mc_flags;
  logic [15:0] addr;
  logic [7:0]  wr_data;
  logic        stall;
  logic [7:0]  rd_data;
  logic        rd_valid;
  logic        ext_ads_n;
  logic        ext_rds_n;
  logic        ext_wds_n;
  logic [11:0] ext_addr;
  logic [7:0]  ext_db_out;
  logic        ext_db_oe;
  logic [7:0]  ext_db_in;
  logic        ext_hold_n;
  logic        ext_breq_out;
  logic        ext_enin;
  logic        ext_enout;

  modport master (
    input  mc_ads, mc_rd, mc_wr, mc_flags, addr, wr_data,
    input  ext_db_in, ext_hold_n, ext_enin,
    output stall, rd_data, rd_valid,
    output ext_ads_n, ext_rds_n, ext_wds_n, ext_addr, ext_db_out, ext_db_oe,
    output ext_breq_out, ext_enout
  );

  modport slave (
    output mc_ads, mc_rd, mc_wr, mc_flags, addr, wr_data,
    output ext_db_in, ext_hold_n, ext_enin,
    input  stall, rd_data, rd_valid,
    input  ext_ads_n, ext_rds_n, ext_wds_n, ext_addr, ext_db_out, ext_db_oe,
    input  ext_breq_out, ext_enout
  );
endinterface

// File: rtl/scmp_bus_ctl_arb.sv
// BREQ/ENIN/ENOUT daisy-chain handshake; grant tells the FSM it may leave ARB.
// Arbitration exists only when SCMP_BUS_ARB_EN is defined; otherwise grant is constant 1.
module scmp_bus_arb (
  input  logic clk,
  input  logic rst,
  input  logic breq_nxt,
  input  logic ext_enin,
  output logic ext_breq_out,
  output logic ext_enout,
  output logic grant
);

`ifdef SCMP_BUS_ARB_EN
  logic breq_r;

  // Bus request register, high from ARB through the end of DATA.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      breq_r <= 1'b0;
    end else begin
      breq_r <= breq_nxt;
    end
  end

  assign ext_breq_out = breq_r;
  // Pass the grant down the chain only while we are not requesting.
  assign ext_enout    = ~rst & ext_enin & ~breq_r;
  assign grant        = ext_enin;
`else
  logic unused_arb_s;
  assign unused_arb_s = ^{clk, rst, breq_nxt, ext_enin};
  assign ext_breq_out = 1'b0;
  assign ext_enout    = 1'b0;
  assign grant        = 1'b1;
`endif

endmodule

// File: rtl/scmp_bus_ctl.sv
// SC/MP external bus cycle controller: turns sequencer bus requests into ADS/RDS/WDS cycles.
// Optional arbitration is compiled in with SCMP_BUS_ARB_EN.
module scmp_bus_ctl
  import scmp_bus_pak::*;
#(
  parameter int STROBE_CYCLES = 2
) (
  input  logic           clk,
  input  logic           rst,
  scmp_bus_ctl_if.master bus
);

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(STROBE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

`ifdef SCMP_BUS_ARB_EN
  localparam BUS_STATE_t ST_REQ = ST_ARB;
`else
  localparam BUS_STATE_t ST_REQ = ST_ADDR;
`endif

  BUS_STATE_t       state_r;
  BUS_STATE_t       state_nxt_s;
  logic [CNT_W-1:0] cnt_r;
  logic             is_rd_r;
  logic             is_wr_r;
  logic             final_s;
  logic             grant_s;
  logic             breq_nxt_s;

  logic             ext_ads_n_r;
  logic             ext_rds_n_r;
  logic             ext_wds_n_r;
  logic [11:0]      ext_addr_r;
  logic [7:0]       ext_db_out_r;
  logic             ext_db_oe_r;
  logic [7:0]       rd_data_r;
  logic             rd_valid_r;

  assign breq_nxt_s = (state_nxt_s != ST_IDLE);

  scmp_bus_arb u_arb (
    .clk          (clk),
    .rst          (rst),
    .breq_nxt     (breq_nxt_s),
    .ext_enin     (bus.ext_enin),
    .ext_breq_out (bus.ext_breq_out),
    .ext_enout    (bus.ext_enout),
    .grant        (grant_s)
  );

  // Next-state decode and identification of the final bus cycle.
  always_comb begin
    state_nxt_s = state_r;
    final_s     = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (bus.mc_ads) begin
          state_nxt_s = ST_REQ;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_ARB: begin
        if (grant_s) begin
          state_nxt_s = ST_ADDR;
        end else begin
          state_nxt_s = ST_ARB;
        end
      end
      ST_ADDR: begin
        if (is_rd_r | is_wr_r) begin
          state_nxt_s = ST_DATA;
        end else begin
          state_nxt_s = ST_IDLE;
          final_s     = 1'b1;
        end
      end
      ST_DATA: begin
        // Hold only stretches the strobe once the minimum length has elapsed.
        if ((cnt_r == CNT_ZERO) && bus.ext_hold_n) begin
          state_nxt_s = ST_IDLE;
          final_s     = 1'b1;
        end else begin
          state_nxt_s = ST_DATA;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
        final_s     = 1'b0;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Request capture at the IDLE edge; a simultaneous read and write keeps only the read.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      is_rd_r <= 1'b0;
      is_wr_r <= 1'b0;
    end else if ((state_r == ST_IDLE) && bus.mc_ads) begin
      is_rd_r <= bus.mc_rd;
      is_wr_r <= bus.mc_wr & ~bus.mc_rd;
    end else begin
      is_rd_r <= is_rd_r;
      is_wr_r <= is_wr_r;
    end
  end

  // Data strobe length counter, preloaded on entry to DATA.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_r <= CNT_ZERO;
    end else if ((state_r != ST_DATA) && (state_nxt_s == ST_DATA)) begin
      cnt_r <= CNT_LOAD;
    end else if ((state_r == ST_DATA) && (cnt_r != CNT_ZERO)) begin
      cnt_r <= cnt_r - CNT_ONE;
    end else if (state_nxt_s == ST_IDLE) begin
      cnt_r <= CNT_ZERO;
    end else begin
      cnt_r <= cnt_r;
    end
  end

  // External strobes and bus drive, registered from the next state so they decode from state only.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ext_ads_n_r  <= 1'b1;
      ext_rds_n_r  <= 1'b1;
      ext_wds_n_r  <= 1'b1;
      ext_addr_r   <= 12'h000;
      ext_db_out_r <= 8'h00;
      ext_db_oe_r  <= 1'b0;
    end else begin
      ext_ads_n_r <= ~(state_nxt_s == ST_ADDR);
      ext_rds_n_r <= ~((state_nxt_s == ST_DATA) & is_rd_r);
      ext_wds_n_r <= ~((state_nxt_s == ST_DATA) & is_wr_r);
      ext_db_oe_r <= (state_nxt_s == ST_ADDR) | ((state_nxt_s == ST_DATA) & is_wr_r);
      if (state_nxt_s == ST_ADDR) begin
        ext_addr_r   <= bus.addr[11:0];
        ext_db_out_r <= addr_phase_db(bus.mc_flags, bus.addr);
      end else if ((state_nxt_s == ST_DATA) && is_wr_r) begin
        ext_addr_r   <= ext_addr_r;
        ext_db_out_r <= bus.wr_data;
      end else begin
        ext_addr_r   <= ext_addr_r;
        ext_db_out_r <= ext_db_out_r;
      end
    end
  end

  // Read data capture on the edge that closes a read's final strobe cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_data_r  <= 8'h00;
      rd_valid_r <= 1'b0;
    end else if ((state_r == ST_DATA) && final_s && is_rd_r) begin
      rd_data_r  <= bus.ext_db_in;
      rd_valid_r <= 1'b1;
    end else begin
      rd_data_r  <= rd_data_r;
      rd_valid_r <= 1'b0;
    end
  end

  assign bus.ext_ads_n  = ext_ads_n_r;
  assign bus.ext_rds_n  = ext_rds_n_r;
  assign bus.ext_wds_n  = ext_wds_n_r;
  assign bus.ext_addr   = ext_addr_r;
  assign bus.ext_db_out = ext_db_out_r;
  assign bus.ext_db_oe  = ext_db_oe_r;
  assign bus.rd_data    = rd_data_r;
  assign bus.rd_valid   = rd_valid_r;

  // The sequencer advances on the edge that ends the final cycle, so a held request never restarts.
  assign bus.stall = ~rst & (((state_r == ST_IDLE) & bus.mc_ads) |
                             ((state_r != ST_IDLE) & ~final_s));

endmodule

// File: tb/tb_scmp_bus_ctl.sv
// Self-checking bench for scmp_bus_ctl: vector table, reset corner cases and random transactions.
// Expected cycle timelines are built from the bus-cycle rules, not from the controller's internals.
module tb_scmp_bus_ctl;

  localparam int SC = 2;
`ifdef SCMP_BUS_ARB_EN
  localparam bit ARB = 1'b1;
`else
  localparam bit ARB = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  int   errors = 0;
  int   checks = 0;
  logic [7:0] rd_m = 8'h00;

  scmp_bus_ctl_if bus ();

  scmp_bus_ctl #(.STROBE_CYCLES(SC)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rd;
    logic        wr;
    logic [3:0]  fl;
    logic [15:0] a;
    logic [7:0]  wd;
    logic [7:0]  dbin;
    int          holds;
    int          enin_low;
    int          exp_stall;
    logic [7:0]  exp_rd;
  } vec_t;

  vec_t tv [6];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Compare one sampled cycle against its expected bus picture.
  task automatic chk_cycle(input string tag, input logic [3:0] exp_str, input logic exp_stall,
                           input logic exp_breq, input logic exp_enout, input logic exp_rdv,
                           input bit do_addr, input logic [11:0] exp_addr,
                           input bit do_db, input logic [7:0] exp_db);
    chk({tag, " ads/rds/wds/oe"}, {28'd0, bus.ext_ads_n, bus.ext_rds_n, bus.ext_wds_n, bus.ext_db_oe},
        {28'd0, exp_str});
    chk({tag, " stall"}, {31'd0, bus.stall}, {31'd0, exp_stall});
    chk({tag, " breq/enout"}, {30'd0, bus.ext_breq_out, bus.ext_enout}, {30'd0, exp_breq, exp_enout});
    chk({tag, " rd_valid/rd_data"}, {23'd0, bus.rd_valid, bus.rd_data}, {23'd0, exp_rdv, rd_m});
    if (do_addr) chk({tag, " ext_addr"}, {20'd0, bus.ext_addr}, {20'd0, exp_addr});
    if (do_db) chk({tag, " ext_db_out"}, {24'd0, bus.ext_db_out}, {24'd0, exp_db});
  endtask

  task automatic drive_idle();
    bus.mc_ads     = 1'b0;
    bus.mc_rd      = 1'b0;
    bus.mc_wr      = 1'b0;
    bus.mc_flags   = 4'h0;
    bus.addr       = 16'h0000;
    bus.wr_data    = 8'h00;
    bus.ext_db_in  = 8'h00;
    bus.ext_hold_n = 1'b1;
    bus.ext_enin   = 1'b1;
  endtask

  // One full sequencer request, checked cycle by cycle; returns the number of stalled cycles.
  task automatic run_txn(input logic rd, input logic wr, input logic [3:0] fl, input logic [15:0] a,
                         input logic [7:0] wd, input logic [7:0] dbin, input int holds,
                         input int enin_low, input bit noise, output int stall_cnt);
    logic is_rd;
    logic is_wr;
    int   n_data;
    int   n_arb;
    is_rd     = rd;
    is_wr     = wr & ~rd;
    n_data    = (rd | wr) ? SC + holds : 0;
    n_arb     = ARB ? 1 + enin_low : 0;
    stall_cnt = 0;

    @(posedge clk); #1;
    bus.mc_ads = 1'b1; bus.mc_rd = rd; bus.mc_wr = wr; bus.mc_flags = fl;
    bus.addr = a; bus.wr_data = wd; bus.ext_db_in = dbin; bus.ext_hold_n = 1'b1; bus.ext_enin = 1'b1;
    @(negedge clk);
    chk_cycle("req", 4'b1110, 1'b1, 1'b0, ARB, 1'b0, 1'b0, 12'h0, 1'b0, 8'h0);
    stall_cnt += int'(bus.stall);

    for (int i = 0; i < n_arb; i++) begin
      @(posedge clk); #1;
      bus.ext_enin = (i >= enin_low);
      @(negedge clk);
      chk_cycle("arb", 4'b1110, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 12'h0, 1'b0, 8'h0);
      stall_cnt += int'(bus.stall);
    end

    @(posedge clk); #1;
    bus.ext_enin = 1'b1;
    @(negedge clk);
    chk_cycle("ads", 4'b0111, (n_data != 0), ARB, 1'b0, 1'b0, 1'b1, a[11:0], 1'b1, {fl, a[15:12]});
    stall_cnt += int'(bus.stall);

    for (int j = 0; j < n_data; j++) begin
      @(posedge clk); #1;
      if (j >= SC - 1 && j < SC - 1 + holds) bus.ext_hold_n = 1'b0;
      else if (noise && j < SC - 1) bus.ext_hold_n = 1'($urandom_range(0, 1));
      else bus.ext_hold_n = 1'b1;
      @(negedge clk);
      chk_cycle(is_rd ? "rds" : "wds", {1'b1, ~is_rd, ~is_wr, is_wr}, (j != n_data - 1),
                ARB, 1'b0, 1'b0, 1'b1, a[11:0], is_wr, wd);
      stall_cnt += int'(bus.stall);
    end

    @(posedge clk); #1;
    bus.mc_ads = 1'b0; bus.mc_rd = 1'b0; bus.mc_wr = 1'b0; bus.ext_hold_n = 1'b1;
    if (is_rd) rd_m = dbin;
    @(negedge clk);
    chk_cycle("post", 4'b1110, 1'b0, 1'b0, ARB, is_rd, 1'b0, 12'h0, 1'b0, 8'h0);
  endtask

  initial begin
    int sc;
    int exp_sc;
    logic rr, ww;
    int hh, ee;

    tv[0] = '{1'b1, 1'b0, 4'b0101, 16'hA123, 8'h00, 8'h5A, 0, 0, 3, 8'h5A};
    tv[1] = '{1'b0, 1'b1, 4'b1010, 16'h0F0E, 8'hC3, 8'h77, 3, 0, 6, 8'h5A};
    tv[2] = '{1'b0, 1'b0, 4'b1111, 16'h1234, 8'h11, 8'h22, 0, 4, 1, 8'h5A};
    tv[3] = '{1'b1, 1'b1, 4'b0011, 16'h8001, 8'hAA, 8'h3C, 1, 1, 4, 8'h3C};
    tv[4] = '{1'b1, 1'b0, 4'b1111, 16'hFFFF, 8'h00, 8'h00, 0, 2, 3, 8'h00};
    tv[5] = '{1'b0, 1'b1, 4'b0000, 16'h0000, 8'hFF, 8'h99, 0, 0, 3, 8'h00};

    // Reset: outputs at rest, stall suppressed even with a request pending.
    drive_idle();
    rst = 1'b1;
    bus.mc_ads = 1'b1;
    #12;
    chk_cycle("reset", 4'b1110, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 12'h000, 1'b1, 8'h00);
    @(negedge clk);
    bus.mc_ads = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    chk_cycle("idle", 4'b1110, 1'b0, 1'b0, ARB, 1'b0, 1'b1, 12'h000, 1'b1, 8'h00);

    for (int k = 0; k < 6; k++) begin
      run_txn(tv[k].rd, tv[k].wr, tv[k].fl, tv[k].a, tv[k].wd, tv[k].dbin,
              tv[k].holds, tv[k].enin_low, 1'b0, sc);
      exp_sc = tv[k].exp_stall + (ARB ? 1 + tv[k].enin_low : 0);
      chk($sformatf("vec%0d stall cycles", k), sc, exp_sc);
      chk($sformatf("vec%0d rd_data", k), {24'd0, bus.rd_data}, {24'd0, tv[k].exp_rd});
    end

    // Reset asserted in the middle of a read strobe.
    @(posedge clk); #1;
    bus.mc_ads = 1'b1; bus.mc_rd = 1'b1; bus.addr = 16'h4567; bus.ext_db_in = 8'hE1;
    for (int i = 0; i < (ARB ? 2 : 1); i++) @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    chk("midrst rds active", {31'd0, bus.ext_rds_n}, 32'd0);
    #2 rst = 1'b1;
    #1;
    rd_m = 8'h00;
    chk_cycle("midrst", 4'b1110, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 12'h0, 1'b0, 8'h0);
    @(negedge clk);
    drive_idle();
    rst = 1'b0;
    run_txn(1'b1, 1'b0, 4'b1001, 16'h4567, 8'h00, 8'hE1, 1, 0, 1'b0, sc);
    chk("after reset stall cycles", sc, 4 + (ARB ? 1 : 0));

    // Random transactions against the timing rules.
    for (int r = 0; r < 40; r++) begin
      rr = 1'($urandom_range(0, 1));
      ww = 1'($urandom_range(0, 1));
      hh = $urandom_range(0, 3);
      ee = $urandom_range(0, 3);
      run_txn(rr, ww, 4'($urandom), 16'($urandom), 8'($urandom), 8'($urandom), hh, ee, 1'b1, sc);
      exp_sc = 1 + (ARB ? 1 + ee : 0) + ((rr | ww) ? SC + hh : 0);
      chk($sformatf("rand%0d stall cycles", r), sc, exp_sc);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
